// File: rtl/led_arbiter_pkg.sv
// Shared types and defaults for the LED bank arbiter.
// The state enum is also exported on the top's debug port.
package led_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } arb_state_e;

    localparam int DEFAULT_LED_W       = 16;
    localparam int DEFAULT_HOLD_CYCLES = 4007900;  // ~100 ms at 40.079 MHz
    localparam int DWELL_W             = 23;
    localparam int SWITCH_W            = 16;

endpackage

// File: rtl/led_arbiter_prio_enc.sv
// Combinational lowest-index priority encoder: index 0 wins.
module prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        // Scan from the top so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Priority arbiter granting one requester the LED bank for a minimum dwell.
// state_o and dwell_o expose the FSM state and dwell counter for debug.
module led_arbiter
    import led_arbiter_pkg::*;
#(
    parameter  int N_SRC       = 4,
    parameter  int LED_W       = DEFAULT_LED_W,
    parameter  int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    localparam int IDX_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_SRC-1:0]       req_i,
    input  logic [N_SRC*LED_W-1:0] pattern_i,
    output logic [LED_W-1:0]       led_out,
    output logic [N_SRC-1:0]       grant_o,
    output logic [IDX_W-1:0]       owner_o,
    output logic [SWITCH_W-1:0]    switch_cnt_o,
    output arb_state_e             state_o,
    output logic [DWELL_W-1:0]     dwell_o
);

    arb_state_e          state_q,  state_d;
    logic [IDX_W-1:0]    owner_q,  owner_d;
    logic [DWELL_W-1:0]  dwell_q,  dwell_d;
    logic [N_SRC-1:0]    grant_q,  grant_d;
    logic [LED_W-1:0]    led_q,    led_d;
    logic [SWITCH_W-1:0] switch_q, switch_d;

    logic             any_req;
    logic [IDX_W-1:0] low_idx;
    logic             expired;
    logic             take;

    prio_enc #(.N(N_SRC), .IDX_W(IDX_W)) u_prio_enc (
        .req_i   (req_i),
        .valid_o (any_req),
        .idx_o   (low_idx)
    );

    // The cycle in which the counter sits at 0 is already past the dwell, so the
    // owner is held for exactly HOLD_CYCLES cycles before a change can happen.
    assign expired = (state_q == ST_OPEN) || ((state_q == ST_HOLD) && (dwell_q == '0));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        dwell_d = dwell_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                take = any_req;
            end
            ST_HOLD, ST_OPEN: begin
                if (expired) begin
                    if (!req_i[owner_q]) begin
                        if (any_req) begin
                            take = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            owner_d = '0;
                            dwell_d = '0;
                        end
                    end else if (low_idx < owner_q) begin
                        take = 1'b1;
                    end else begin
                        state_d = ST_OPEN;
                    end
                end else if (req_i[0] && (owner_q != '0)) begin
                    take = 1'b1;
                end else begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
                dwell_d = '0;
            end
        endcase

        // take always lands on a different index, so it is always a real owner change.
        if (take) begin
            state_d = ST_HOLD;
            owner_d = low_idx;
            dwell_d = DWELL_W'(HOLD_CYCLES - 1);
        end

        switch_d = (take && (switch_q != '1)) ? switch_q + SWITCH_W'(1) : switch_q;

        grant_d = '0;
        led_d   = '0;
        if (state_d != ST_IDLE) begin
            grant_d[owner_d] = 1'b1;
            led_d            = pattern_i[owner_d*LED_W +: LED_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            dwell_q  <= '0;
            grant_q  <= '0;
            led_q    <= '0;
            switch_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            dwell_q  <= dwell_d;
            grant_q  <= grant_d;
            led_q    <= led_d;
            switch_q <= switch_d;
        end
    end

    assign led_out      = led_q;
    assign grant_o      = grant_q;
    assign owner_o      = owner_q;
    assign switch_cnt_o = switch_q;
    assign state_o      = state_q;
    assign dwell_o      = dwell_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Bench for led_arbiter: vector table, directed dwell/preempt/reset sequences,
// random traffic against a timestamp-based model, and counter saturation.
module tb_led_arbiter;
    import led_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int LW = 16;
    localparam int H  = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset = 1'b1;
    logic [N-1:0]       req   = '0;
    logic [N*LW-1:0]    pat   = '0;
    logic [LW-1:0]      led;
    logic [N-1:0]       grant;
    logic [1:0]         owner;
    logic [15:0]        swc;
    arb_state_e         st;
    logic [DWELL_W-1:0] dwell;

    logic               s_reset = 1'b1;
    logic [N-1:0]       s_req   = '0;
    logic [N*LW-1:0]    s_pat   = '0;
    logic [LW-1:0]      s_led;
    logic [N-1:0]       s_grant;
    logic [1:0]         s_owner;
    logic [15:0]        s_swc;
    arb_state_e         s_st;
    logic [DWELL_W-1:0] s_dwell;

    led_arbiter #(.N_SRC(N), .LED_W(LW), .HOLD_CYCLES(H)) dut (
        .clock(clock), .reset(reset), .req_i(req), .pattern_i(pat),
        .led_out(led), .grant_o(grant), .owner_o(owner), .switch_cnt_o(swc),
        .state_o(st), .dwell_o(dwell)
    );

    led_arbiter #(.N_SRC(N), .LED_W(LW), .HOLD_CYCLES(1)) dut_sat (
        .clock(clock), .reset(s_reset), .req_i(s_req), .pattern_i(s_pat),
        .led_out(s_led), .grant_o(s_grant), .owner_o(s_owner), .switch_cnt_o(s_swc),
        .state_o(s_st), .dwell_o(s_dwell)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner index (-1 = none) and the edge number at which it was granted.
    int          m_owner = -1;
    int          m_gedge = 0;
    int          m_edge  = 0;
    int          m_sw    = 0;
    logic [15:0] m_led   = '0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [1:0]  e_owner;
        logic [3:0]  e_grant;
        logic [15:0] e_led;
        logic [15:0] e_sw;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] r);
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic model_edge();
        int lo;
        int nxt;
        m_edge++;
        if (reset) begin
            m_owner = -1;
            m_sw    = 0;
        end else begin
            lo  = lowest(req);
            nxt = m_owner;
            if (m_owner < 0) nxt = lo;
            else if (m_edge - m_gedge >= H) begin
                if (!req[m_owner]) nxt = lo;
                else if (lo < m_owner) nxt = lo;
            end else if (req[0] && m_owner != 0) nxt = 0;
            if (nxt != m_owner) begin
                if (nxt >= 0) begin
                    m_gedge = m_edge;
                    if (m_sw < 65535) m_sw++;
                end
                m_owner = nxt;
            end
        end
        m_led = (m_owner < 0) ? 16'h0 : pat[m_owner*LW +: LW];
    endtask

    task automatic compare_all();
        int el;
        logic [31:0] e_st;
        logic [31:0] e_dw;
        el = m_edge - m_gedge;
        if (m_owner < 0) begin
            e_st = 32'(ST_IDLE);
            e_dw = 0;
        end else if (el < H) begin
            e_st = 32'(ST_HOLD);
            e_dw = 32'(H - 1 - el);
        end else begin
            e_st = 32'(ST_OPEN);
            e_dw = 0;
        end
        check("model_owner", 32'(owner), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("model_grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("model_led", 32'(led), 32'(m_led));
        check("model_switch", 32'(swc), 32'(m_sw));
        check("model_state", 32'(st), e_st);
        check("model_dwell", 32'(dwell), e_dw);
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        pat = {16'h3C3C, 16'hA5A5, 16'h2222, 16'h1111};
        tbl[0] = '{1'b1, 4'b0100, 2'd0, 4'b0000, 16'h0000, 16'd0};
        tbl[1] = '{1'b0, 4'b0100, 2'd2, 4'b0100, 16'hA5A5, 16'd1};
        tbl[2] = '{1'b0, 4'b0100, 2'd2, 4'b0100, 16'hA5A5, 16'd1};
        tbl[3] = '{1'b1, 4'b1111, 2'd0, 4'b0000, 16'h0000, 16'd0};
        tbl[4] = '{1'b0, 4'b1110, 2'd1, 4'b0010, 16'h2222, 16'd1};
        tbl[5] = '{1'b1, 4'b0000, 2'd0, 4'b0000, 16'h0000, 16'd0};
        tbl[6] = '{1'b0, 4'b1000, 2'd3, 4'b1000, 16'h3C3C, 16'd1};
        tbl[7] = '{1'b0, 4'b1001, 2'd0, 4'b0001, 16'h1111, 16'd2};
        tbl[8] = '{1'b1, 4'b1001, 2'd0, 4'b0000, 16'h0000, 16'd0};

        for (int i = 0; i < 9; i++) begin
            reset = tbl[i].rst;
            req   = tbl[i].req;
            step();
            check($sformatf("vec%0d_owner", i), 32'(owner), 32'(tbl[i].e_owner));
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
            check($sformatf("vec%0d_led", i), 32'(led), 32'(tbl[i].e_led));
            check($sformatf("vec%0d_switch", i), 32'(swc), 32'(tbl[i].e_sw));
        end

        // Blocked change during dwell, then preemption by a lower index at expiry.
        do_reset();
        req = 4'b0100;
        step();
        check("d31_owner_first", 32'(owner), 32'd2);
        for (int i = 0; i < 3; i++) step();
        req = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            step();
            check("d31_owner_held", 32'(owner), 32'd2);
        end
        step();
        check("d31_owner_new", 32'(owner), 32'd1);
        check("d31_switch", 32'(swc), 32'd2);
        check("d31_led", 32'(led), 32'h2222);

        // Source 0 preempts mid-dwell immediately and reloads the dwell.
        do_reset();
        req = 4'b1000;
        step();
        step();
        step();
        req = 4'b1001;
        step();
        check("d32_owner", 32'(owner), 32'd0);
        check("d32_dwell", 32'(dwell), 32'd7);
        check("d32_switch", 32'(swc), 32'd2);

        // Dropped request keeps the grant and live pattern until expiry, then idle.
        do_reset();
        req = 4'b0010;
        step();
        step();
        req = 4'b0000;
        for (int i = 0; i < 2; i++) step();
        pat[31:16] = 16'h5A5A;
        step();
        check("d33_owner_held", 32'(owner), 32'd1);
        check("d33_led_track", 32'(led), 32'h5A5A);
        for (int i = 0; i < 3; i++) step();
        check("d33_still_owner", 32'(owner), 32'd1);
        step();
        check("d33_idle_led", 32'(led), 32'h0000);
        check("d33_idle_grant", 32'(grant), 32'd0);
        check("d33_idle_state", 32'(st), 32'(ST_IDLE));
        check("d33_switch", 32'(swc), 32'd1);
        pat[31:16] = 16'h2222;

        // Reset pulse mid-dwell aborts it; re-grant follows with a fresh dwell.
        do_reset();
        req = 4'b0100;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        check("d34_rst_owner", 32'(owner), 32'd0);
        check("d34_rst_led", 32'(led), 32'd0);
        check("d34_rst_switch", 32'(swc), 32'd0);
        check("d34_rst_dwell", 32'(dwell), 32'd0);
        reset = 1'b0;
        step();
        check("d34_regrant_owner", 32'(owner), 32'd2);
        check("d34_regrant_switch", 32'(swc), 32'd1);
        check("d34_regrant_dwell", 32'(dwell), 32'd7);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            pat[$urandom_range(0, 3)*LW +: LW] = 16'($urandom);
            step();
        end
        reset = 1'b0;
        req   = '0;

        // Saturation: with a 1-cycle dwell, alternating requests swap the owner every edge.
        s_pat = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        s_reset = 1'b1;
        @(posedge clock);
        #1;
        check("sat_reset_switch", 32'(s_swc), 32'd0);
        s_reset = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            s_req = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            @(posedge clock);
            #1;
            if (i == 0) check("sat_first", 32'(s_swc), 32'd1);
            if (i == 65533) check("sat_before_top", 32'(s_swc), 32'hFFFE);
        end
        check("sat_switch", 32'(s_swc), 32'hFFFF);
        check("sat_owner", 32'(s_owner), 32'd1);
        check("sat_led", 32'(s_led), 32'h2222);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter N_SRC, default 4: number of LED requesters; index 0 is highest priority.
REQ-002 Parameter LED_W, default 16: LED bank width.
REQ-003 Parameter HOLD_CYCLES, default 4007900: minimum grant dwell in clock cycles (~100 ms at 40.079 MHz); legal range 1..2^23-1.
REQ-004 clock  in  1  single 40 MHz fabric clock; all logic is on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_i  in  N_SRC  per-source request level; bit i asks for ownership of the LED bank.
REQ-007 pattern_i  in  N_SRC*LED_W  per-source LED pattern; source i occupies bits [i*LED_W +: LED_W].
REQ-008 led_out  out  LED_W  registered LED drive, taken from the current owner's pattern.
REQ-009 grant_o  out  N_SRC  registered owner vector; one-hot or all-zero.
REQ-010 owner_o  out  clog2(N_SRC)  registered index of the owner; 0 when idle.
REQ-011 switch_cnt_o  out  16  count of grant changes; saturates at 0xFFFF.

Function
REQ-012 FSM states: IDLE (no owner), HOLD (owner set, dwell counter running), OPEN (owner set, dwell expired).
REQ-013 IDLE: if any req_i bit is set, grant the lowest set index next cycle, load the dwell counter with HOLD_CYCLES-1, then go to HOLD.
REQ-014 HOLD: the dwell counter decrements by 1 per cycle; at 0 go to OPEN.
REQ-015 HOLD: a grant change is blocked, except that req_i[0] asserted while owner!=0 preempts immediately.
REQ-016 HOLD: the owner dropping its request does not release the grant; led_out continues to track that owner's pattern_i until the dwell expires.
REQ-017 OPEN: if the owner's request is low, grant the lowest requesting index (reload dwell, go to HOLD), or go to IDLE if none requests.
REQ-018 OPEN: if a lower-index source requests, preempt (reload dwell, go to HOLD); higher-index requests are ignored while the owner still requests.
REQ-019 Re-grant of the same index is not a grant change: no counter reload and no switch_cnt_o increment.
REQ-020 led_out equals the owner's pattern_i sampled one cycle earlier (1-cycle latency); in IDLE, led_out is all zeros.
REQ-021 grant_o, owner_o and led_out update in the same cycle; led_out never shows a mix of two sources.
REQ-022 switch_cnt_o increments by 1 on each owner change, including IDLE->owner; owner->IDLE does not increment.
REQ-023 With simultaneous requests, the lowest index wins.
REQ-024 An out-of-range or glitching req_i cannot produce a multi-hot grant_o.

Reset
REQ-025 On reset: state IDLE, grant_o=0, owner_o=0, led_out=0, dwell counter=0, switch_cnt_o=0.
REQ-026 Reset asserted mid-HOLD aborts the dwell; the first grant after reset release follows REQ-013 with no residual hold.

Structure
REQ-027 A shared package holds the state enum (IDLE/HOLD/OPEN), the default HOLD_CYCLES and the LED_W constant.
REQ-028 Sub-module prio_enc: a combinational lowest-index priority encoder (N_SRC in -> valid + index), instantiated once.
REQ-029 The dwell counter is 23 bits wide and down-counting; there is no second clock domain.

Verification (HOLD_CYCLES=8, N_SRC=4)
REQ-030 req_i=0100, pattern2=0xA5A5 from reset -> owner_o=2 and led_out=0xA5A5 two cycles after request; switch_cnt_o=1.
REQ-031 Owner 2 in HOLD, req_i becomes 0110 at dwell cycle 3 -> no change until the counter expires, then owner_o=1; switch_cnt_o=2.
REQ-032 Owner 3 in HOLD, req_i[0] rises at dwell cycle 2 -> owner_o=0 on the next cycle, dwell reloaded to 7.
REQ-033 Owner 1 drops its request at dwell cycle 1 with no other request -> led_out keeps tracking pattern1 until expiry, then IDLE with led_out=0x0000.
REQ-034 Owner 2 mid-HOLD with reset pulsed 1 cycle and req_i held at 0100 -> all outputs 0 in the reset cycle, then re-grant to 2 with switch_cnt_o=1.
REQ-035 Force 65540 owner changes -> switch_cnt_o holds at 0xFFFF.
